ccsds123_sample_sequencer: RTL and testbench

//  Input-side controller for the CCSDS-123 compressor pipeline. Accepts raw samples on an AXI-Stream slave
//  in BIP order (z fastest, then x, then y) and tags each one with its (x,y,z) position and edge flags.

---
 rtl/ccsds123_sample_sequencer.sv | 126 ++++++++++++
 tb/tb_ccsds123_sample_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccsds123_sample_sequencer.sv
// Input sequencer for the CCSDS-123 pipeline: tags BIP-ordered samples with (x,y,z) and edge flags,
// forwards them through a one-stage register slice, then drains and flushes before pulsing done.
module ccsds123_sample_sequencer #(
    parameter int unsigned NX           = 4,
    parameter int unsigned NY           = 4,
    parameter int unsigned NZ           = 16,
    parameter int unsigned D            = 16,
    parameter int unsigned FLUSH_CYCLES = 32,
    localparam int unsigned XW = (NX > 1) ? $clog2(NX) : 1,
    localparam int unsigned YW = (NY > 1) ? $clog2(NY) : 1,
    localparam int unsigned ZW = (NZ > 1) ? $clog2(NZ) : 1,
    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          start,
    input  logic [D-1:0]  s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic [D-1:0]  m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [XW-1:0] m_x,
    output logic [YW-1:0] m_y,
    output logic [ZW-1:0] m_z,
    output logic          m_first_line,
    output logic          m_first_in_line,
    output logic          m_last_in_line,
    output logic          m_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFlush} state_e;

    state_e        state;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [ZW-1:0] z_cnt;
    logic [FW-1:0] flush_cnt;
    logic          accept;
    logic          x_end;
    logic          y_end;
    logic          z_end;

    assign s_axis_tready = (state == StRun) && (!m_tvalid || m_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign x_end         = (x_cnt == XW'(NX - 1));
    assign y_end         = (y_cnt == YW'(NY - 1));
    assign z_end         = (z_cnt == ZW'(NZ - 1));
    assign busy          = (state != StIdle);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state           <= StIdle;
            x_cnt           <= '0;
            y_cnt           <= '0;
            z_cnt           <= '0;
            flush_cnt       <= '0;
            m_tdata         <= '0;
            m_tvalid        <= 1'b0;
            m_x             <= '0;
            m_y             <= '0;
            m_z             <= '0;
            m_first_line    <= 1'b0;
            m_first_in_line <= 1'b0;
            m_last_in_line  <= 1'b0;
            m_last          <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) state <= StRun;
                end
                StRun: begin
                    if (accept) begin
                        // Tags describe the accepted sample, so they use the pre-increment counters.
                        m_tdata         <= s_axis_tdata;
                        m_tvalid        <= 1'b1;
                        m_x             <= x_cnt;
                        m_y             <= y_cnt;
                        m_z             <= z_cnt;
                        m_first_line    <= (y_cnt == '0);
                        m_first_in_line <= (x_cnt == '0);
                        m_last_in_line  <= x_end;
                        m_last          <= x_end && y_end && z_end;
                        if (z_end) begin
                            z_cnt <= '0;
                            if (x_end) begin
                                x_cnt <= '0;
                                y_cnt <= y_end ? '0 : y_cnt + YW'(1);
                            end else begin
                                x_cnt <= x_cnt + XW'(1);
                            end
                        end else begin
                            z_cnt <= z_cnt + ZW'(1);
                        end
                        if (x_end && y_end && z_end) state <= StDrain;
                    end else if (m_tready) begin
                        m_tvalid <= 1'b0;
                    end
                end
                StDrain: begin
                    if (m_tvalid && m_tready) begin
                        m_tvalid <= 1'b0;
                        state    <= StFlush;
                        done     <= (FLUSH_CYCLES == 1);
                    end
                end
                StFlush: begin
                    // done is registered so it is high during the final FLUSH cycle, where start is ignored.
                    if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
                        flush_cnt <= '0;
                        state     <= StIdle;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                        done      <= (flush_cnt == FW'(FLUSH_CYCLES - 2));
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ccsds123_sample_sequencer.sv
// Self-checking bench for ccsds123_sample_sequencer: default 4x4x16 instance plus a 3x5x7 instance,
// checked against a position model derived from the sample index by division and modulo.
module tb_ccsds123_sample_sequencer;

    localparam int NA  = 256;
    localparam int FL  = 32;
    localparam int NB  = 105;
    localparam int FLB = 4;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        start, s_tvalid, s_tready, m_tvalid, m_tready;
    logic [15:0] s_tdata, m_tdata;
    logic [1:0]  m_x, m_y;
    logic [3:0]  m_z;
    logic        m_fl, m_fil, m_lil, m_last, busy, done;

    // Non-power-of-two instance
    logic        b_start, b_tvalid, b_tready, b_mvalid, b_mready;
    logic [15:0] b_tdata, b_mdata;
    logic [1:0]  b_x;
    logic [2:0]  b_y, b_z;
    logic        b_fl, b_fil, b_lil, b_last, b_busy, b_done;

    ccsds123_sample_sequencer dut_a (
        .clk(clk), .areset(areset), .start(start),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_x(m_x), .m_y(m_y), .m_z(m_z),
        .m_first_line(m_fl), .m_first_in_line(m_fil), .m_last_in_line(m_lil), .m_last(m_last),
        .busy(busy), .done(done)
    );

    ccsds123_sample_sequencer #(
        .NX(3), .NY(5), .NZ(7), .D(16), .FLUSH_CYCLES(FLB)
    ) dut_b (
        .clk(clk), .areset(areset), .start(b_start),
        .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
        .m_tdata(b_mdata), .m_tvalid(b_mvalid), .m_tready(b_mready),
        .m_x(b_x), .m_y(b_y), .m_z(b_z),
        .m_first_line(b_fl), .m_first_in_line(b_fil), .m_last_in_line(b_lil), .m_last(b_last),
        .busy(b_busy), .done(b_done)
    );

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int idx; int x; int y; int z; bit fl; bit fil; bit lil; bit last;
    } vec_t;
    vec_t tbl[7];

    int       cap_x[NA], cap_y[NA], cap_z[NA];
    bit [3:0] cap_f[NA];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // BIP order: z fastest, then x, then y.
    function automatic void pos(input int k, input int nx, input int ny, input int nz,
                                output int x, output int y, output int z);
        z = k % nz;
        x = (k / nz) % nx;
        y = (k / (nz * nx)) % ny;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_mvalid", m_tvalid, 0);
    endtask

    task automatic run_a(input bit bubble, input int stall_at, input int abort_at, output int cycles);
        int in_idx = 0;
        int out_cnt = 0;
        int stall_n = 0;
        int cyc = 0;
        int ex, ey, ez;
        bit acc;
        logic [15:0] acc_d;
        logic [15:0] held = '0;
        while (out_cnt < NA && cyc < 4000) begin
            if (abort_at >= 0 && in_idx == abort_at) break;
            s_tvalid = (in_idx >= NA) ? 1'b1 : (bubble ? ($urandom_range(0, 2) == 0) : 1'b1);
            s_tdata  = (in_idx >= NA) ? 16'hdead : 16'(in_idx);
            m_tready = !(stall_at >= 0 && out_cnt == stall_at && m_tvalid && stall_n < 5);
            #1;
            if (in_idx >= NA) chk("drain_no_accept", s_tready, 0);
            if (!m_tready) begin
                chk("stall_tready", s_tready, 0);
                if (stall_n == 0) held = m_tdata;
                else chk("stall_hold", m_tdata, held);
                stall_n++;
            end
            acc   = s_tvalid && s_tready;
            acc_d = s_tdata;
            if (m_tvalid && m_tready) begin
                pos(out_cnt, 4, 4, 16, ex, ey, ez);
                chk("out_data", m_tdata, out_cnt);
                chk("out_x", m_x, ex);
                chk("out_y", m_y, ey);
                chk("out_z", m_z, ez);
                chk("out_first_line", m_fl, ey == 0);
                chk("out_first_in_line", m_fil, ex == 0);
                chk("out_last_in_line", m_lil, ex == 3);
                chk("out_last", m_last, out_cnt == NA - 1);
                cap_x[out_cnt] = int'(m_x);
                cap_y[out_cnt] = int'(m_y);
                cap_z[out_cnt] = int'(m_z);
                cap_f[out_cnt] = {m_fl, m_fil, m_lil, m_last};
                out_cnt++;
            end
            step();
            cyc++;
            if (acc) begin
                chk("latency_valid", m_tvalid, 1);
                chk("latency_data", m_tdata, acc_d);
                in_idx++;
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        if (abort_at < 0) chk("out_count", out_cnt, NA);
        cycles = cyc;
    endtask

    task automatic flush_a();
        for (int c = 0; c < FL; c++) begin
            chk("flush_busy", busy, 1);
            chk("flush_done", done, c == FL - 1);
            chk("flush_mvalid", m_tvalid, 0);
            chk("flush_tready", s_tready, 0);
            start    = (c == 5 || c == FL - 1);
            s_tvalid = 1'b1;
            step();
            start = 1'b0;
        end
        s_tvalid = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        step();
        step();
        chk("start_in_flush_ignored", busy, 0);
    endtask

    task automatic run_b();
        int in_idx = 0;
        int out_cnt = 0;
        int cyc = 0;
        int ex, ey, ez;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        chk("b_busy", b_busy, 1);
        while (out_cnt < NB && cyc < 3000) begin
            b_tvalid = (in_idx < NB) && ($urandom_range(0, 1) == 1);
            b_tdata  = 16'(in_idx * 3 + 1);
            b_mready = ($urandom_range(0, 3) != 0);
            #1;
            if (b_tvalid && b_tready) in_idx++;
            if (b_mvalid && b_mready) begin
                pos(out_cnt, 3, 5, 7, ex, ey, ez);
                chk("b_data", b_mdata, out_cnt * 3 + 1);
                chk("b_x", b_x, ex);
                chk("b_y", b_y, ey);
                chk("b_z", b_z, ez);
                chk("b_first_line", b_fl, ey == 0);
                chk("b_last_in_line", b_lil, ex == 2);
                chk("b_last", b_last, out_cnt == NB - 1);
                out_cnt++;
            end
            step();
            cyc++;
        end
        chk("b_count", out_cnt, NB);
        b_tvalid = 1'b0;
        b_mready = 1'b1;
        cyc = 0;
        while (!b_done && cyc < 50) begin
            step();
            cyc++;
        end
        chk("b_done", b_done, 1);
        chk("b_flush_len", cyc, FLB - 1);
        step();
        chk("b_idle", b_busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int k;
        start = 0; s_tvalid = 0; s_tdata = '0; m_tready = 1'b1;
        b_start = 0; b_tvalid = 0; b_tdata = '0; b_mready = 1'b1;

        tbl[0] = '{idx: 0,   x: 0, y: 0, z: 0,  fl: 1, fil: 1, lil: 0, last: 0};
        tbl[1] = '{idx: 15,  x: 0, y: 0, z: 15, fl: 1, fil: 1, lil: 0, last: 0};
        tbl[2] = '{idx: 16,  x: 1, y: 0, z: 0,  fl: 1, fil: 0, lil: 0, last: 0};
        tbl[3] = '{idx: 48,  x: 3, y: 0, z: 0,  fl: 1, fil: 0, lil: 1, last: 0};
        tbl[4] = '{idx: 63,  x: 3, y: 0, z: 15, fl: 1, fil: 0, lil: 1, last: 0};
        tbl[5] = '{idx: 64,  x: 0, y: 1, z: 0,  fl: 0, fil: 1, lil: 0, last: 0};
        tbl[6] = '{idx: 255, x: 3, y: 3, z: 15, fl: 0, fil: 0, lil: 1, last: 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_mdata", m_tdata, 0);
        chk("rst_tags", {m_x, m_y, m_z, m_fl, m_fil, m_lil, m_last}, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_b_state", {b_mvalid, b_tready, b_busy, b_done}, 0);
        areset = 1'b0;
        step();
        chk("idle_tready", s_tready, 0);

        // Continuous stream
        do_start();
        run_a(1'b0, -1, -1, cyc);
        chk("no_gaps_cycles", cyc, NA + 1);
        for (int i = 0; i < 7; i++) begin
            k = tbl[i].idx;
            chk($sformatf("tbl_x[%0d]", k), cap_x[k], tbl[i].x);
            chk($sformatf("tbl_y[%0d]", k), cap_y[k], tbl[i].y);
            chk($sformatf("tbl_z[%0d]", k), cap_z[k], tbl[i].z);
            chk($sformatf("tbl_flags[%0d]", k), cap_f[k],
                {tbl[i].fl, tbl[i].fil, tbl[i].lil, tbl[i].last});
        end
        flush_a();

        // Random input bubbles
        do_start();
        run_a(1'b1, -1, -1, cyc);
        flush_a();

        // Output back-pressure for 5 cycles
        do_start();
        run_a(1'b0, 37, -1, cyc);
        chk("stall_cycles", cyc, NA + 1 + 5);
        flush_a();

        // Reset mid-image
        do_start();
        run_a(1'b0, -1, 100, cyc);
        m_tready = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        chk("arst_mvalid", m_tvalid, 0);
        chk("arst_mdata", m_tdata, 0);
        chk("arst_tags", {m_x, m_y, m_z, m_fl, m_fil, m_lil, m_last}, 0);
        chk("arst_tready", s_tready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        step();
        areset   = 1'b0;
        m_tready = 1'b1;
        step();
        chk("arst_idle", busy, 0);
        do_start();
        run_a(1'b0, -1, -1, cyc);
        flush_a();

        // Non-power-of-two dimensions, two images back to back
        run_b();
        run_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
